// File: rtl/fetch_pkg.sv
// Shared core constants for the instruction-fetch path.
package fetch_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned WORD_BYTES = 4;

  // Clear the byte-offset bits so an address points at a whole word.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & ~XLEN'(WORD_BYTES - 1);
  endfunction

endpackage

// File: rtl/fetch.sv
// Instruction fetch: issues word reads, buffers one word across decode stalls,
// and redirects on branches without losing them.
module fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            reset,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  input  logic            mem_ready,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            branch,
  input  logic [XLEN-1:0] branch_address,
  input  logic            stall,
  input  logic            invalidate,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] next_pc_out,
  output logic [XLEN-1:0] instruction_out,
  output logic            valid_out
);

  typedef enum logic [1:0] {
    START   = 2'd0,
    FETCH   = 2'd1,
    HOLD    = 2'd2,
    DISCARD = 2'd3
  } state_e;

  localparam logic [XLEN-1:0] RESET_ADDR = word_align(RESET_VECTOR);
  localparam logic [XLEN-1:0] STEP       = XLEN'(WORD_BYTES);

  state_e          state_q, state_d;
  logic            req_q, req_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] npc_q, npc_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic            valid_q, valid_d;
  logic [XLEN-1:0] hold_instr_q, hold_instr_d;
  logic [XLEN-1:0] hold_pc_q, hold_pc_d;
  logic [XLEN-1:0] target_q, target_d;
  logic [XLEN-1:0] branch_target;

  assign branch_target   = word_align(branch_address);
  assign mem_req         = req_q;
  assign mem_addr        = addr_q;
  assign pc_out          = pc_q;
  assign next_pc_out     = npc_q;
  assign instruction_out = instr_q;
  assign valid_out       = valid_q;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    pc_d         = pc_q;
    npc_d        = npc_q;
    instr_d      = instr_q;
    valid_d      = valid_q;
    hold_instr_d = hold_instr_q;
    hold_pc_d    = hold_pc_q;
    target_d     = target_q;

    // A redirect always kills whatever decode would have seen next.
    if (branch) begin
      target_d = branch_target;
      if (!stall) valid_d = 1'b0;
    end

    unique case (state_q)
      START: begin
        // Any mem_ready here belongs to a request abandoned by reset.
        state_d = FETCH;
        if (branch) addr_d = branch_target;
      end

      FETCH: begin
        if (branch) begin
          if (mem_ready) addr_d = branch_target;
          else           state_d = DISCARD;
        end else if (mem_ready) begin
          addr_d = addr_q + STEP;
          if (stall) begin
            hold_instr_d = mem_rdata;
            hold_pc_d    = addr_q;
            state_d      = HOLD;
          end else begin
            pc_d    = addr_q;
            npc_d   = addr_q + STEP;
            instr_d = mem_rdata;
            valid_d = !invalidate;
          end
        end else if (!stall) begin
          valid_d = 1'b0;
        end
      end

      HOLD: begin
        if (branch) begin
          addr_d  = branch_target;
          state_d = FETCH;
        end else if (!stall) begin
          pc_d    = hold_pc_q;
          npc_d   = hold_pc_q + STEP;
          instr_d = hold_instr_q;
          valid_d = !invalidate;
          state_d = FETCH;
        end
      end

      DISCARD: begin
        if (!stall) valid_d = 1'b0;
        if (mem_ready) begin
          addr_d  = branch ? branch_target : target_q;
          state_d = FETCH;
        end
      end

      default: state_d = START;
    endcase

    req_d = (state_d == FETCH) || (state_d == DISCARD);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= START;
      req_q        <= 1'b0;
      addr_q       <= RESET_ADDR;
      pc_q         <= '0;
      npc_q        <= '0;
      instr_q      <= '0;
      valid_q      <= 1'b0;
      hold_instr_q <= '0;
      hold_pc_q    <= '0;
      target_q     <= '0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      addr_q       <= addr_d;
      pc_q         <= pc_d;
      npc_q        <= npc_d;
      instr_q      <= instr_d;
      valid_q      <= valid_d;
      hold_instr_q <= hold_instr_d;
      hold_pc_q    <= hold_pc_d;
      target_q     <= target_d;
    end
  end

endmodule

// File: doc/fetch.md
FETCH -- requirements
Module: fetch

Interface
REQ-001 The block SHALL have parameter RESET_VECTOR, default 32'h00000000, the first instruction address after reset.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state SHALL change on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 The block SHALL have port mem_req, output, 1, instruction read request.
REQ-005 The block SHALL have port mem_addr, output, 32, word-aligned read address, with bits [1:0] always 0.
REQ-006 The block SHALL have port mem_ready, input, 1, which completes the request in the same cycle, with mem_rdata valid.
REQ-007 The block SHALL have port mem_rdata, input, 32, instruction word.
REQ-008 The block SHALL have ports branch, input, 1, and branch_address, input, 32, the redirect from execute.
REQ-009 The block SHALL have ports stall, input, 1, and invalidate, input, 1, both from hazard.
REQ-010 The block SHALL have outputs pc_out (32), next_pc_out (32), instruction_out (32) and valid_out (1), all registered, to decode.

Function
REQ-011 The block SHALL implement states START, FETCH, HOLD and DISCARD; mem_req SHALL be 1 only in FETCH and DISCARD.
REQ-012 mem_addr and mem_req SHALL be held stable while mem_req=1 and mem_ready=0.
REQ-013 START SHALL go to FETCH after one cycle with mem_addr=RESET_VECTOR.
REQ-014 In FETCH with mem_ready=1, stall=0 and branch=0, the block SHALL, on the next edge, set:
- pc_out=mem_addr, next_pc_out=mem_addr+4, instruction_out=mem_rdata;
- valid_out=!invalidate;
- mem_addr=mem_addr+4;
- state FETCH.
REQ-015 In FETCH with mem_ready=1, stall=1 and branch=0, the block SHALL copy mem_rdata and mem_addr into a one-entry hold buffer, set mem_addr=mem_addr+4, go to HOLD, and leave the decode outputs unchanged.
REQ-016 In FETCH with mem_ready=0 and stall=0, valid_out SHALL become 0 (bubble).
REQ-017 In HOLD with stall=0, the block SHALL drive the buffered instruction to decode exactly as in REQ-014, with valid_out=!invalidate, and go to FETCH.
REQ-018 In HOLD with stall=1, all state and outputs SHALL be held.
REQ-019 A branch in any state SHALL never be lost:
- the target register SHALL be loaded with {branch_address[31:2],2'b00};
- when stall=0, valid_out SHALL become 0.
REQ-020 A branch in FETCH with mem_ready=1 SHALL discard that response, set mem_addr=target and stay in FETCH.
REQ-021 A branch in FETCH with mem_ready=0 SHALL keep mem_addr, store the target and go to DISCARD.
REQ-022 In DISCARD, mem_ready=1 SHALL drop the response, set mem_addr=stored target and go to FETCH; a further branch SHALL overwrite the stored target.
REQ-023 A branch in HOLD SHALL drop the buffered instruction, set mem_addr=target and go to FETCH.
REQ-024 When stall=1, the decode outputs SHALL be held regardless of invalidate; a branch under stall SHALL still redirect fetch.
REQ-025 When stall=0 and invalidate=1, the block SHALL deliver valid_out=0; the fetched word SHALL still be consumed and mem_addr SHALL still advance.
REQ-026 The latency from request acceptance to valid_out SHALL be one cycle, giving a throughput of one instruction per cycle when mem_ready=1 continuously.

Reset
REQ-027 Asserting reset SHALL immediately set:
- state=START, mem_req=0, mem_addr=RESET_VECTOR;
- valid_out=0, pc_out=0, next_pc_out=0, instruction_out=0;
- hold buffer and stored target cleared.
REQ-028 Reset asserted mid-request SHALL abandon the outstanding request; any mem_ready seen in START SHALL be ignored.

Structure
REQ-029 The WORD_BYTES constant (4) SHALL be defined in the shared core package.
REQ-030 The fetch state encoding SHALL be local to the block.
REQ-031 The block SHALL contain no sub-module; the hold buffer SHALL be inline registers.

Verification
REQ-032 Reset release with RESET_VECTOR=32'h100 and mem_ready tied 1 -> mem_addr 0x100, 0x104, 0x108; valid_out rises one cycle after the first accept, with pc_out 0x100 and next_pc_out 0x104.
REQ-033 stall=1 for 3 cycles while 0x104 is returned -> HOLD, mem_req=0, outputs frozen; after release, pc_out=0x104 with instruction_out equal to the buffered word, then 0x108 follows.
REQ-034 branch=1 with branch_address=32'h203 while mem_ready=0 at 0x108 -> DISCARD; the response later returned for 0x108 is dropped; the next mem_addr is 0x200; valid_out=0 until the 0x200 instruction arrives.
REQ-035 invalidate=1 with stall=0 for one cycle on delivery of 0x10C -> valid_out=0 for that cycle; the next instruction is pc_out=0x110.
REQ-036 reset asserted while mem_req=1 and mem_ready=0 -> mem_req falls asynchronously and valid_out=0; after release, the first fetch is RESET_VECTOR.
REQ-037 branch=1 with stall=1 while in HOLD -> the buffered instruction is never delivered; after stall falls, the first valid pc_out is the branch target.
